// File: rtl/issue_scheduler_pkg.sv
// Shared types and sizing for the issue scheduler and its register scoreboard.
package issue_scheduler_pkg;

  localparam int IQ_DEPTH   = 8;
  localparam int WB_PORTS   = 2;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  typedef struct packed {
    logic [31:0]           pc;
    logic [5:0]            op;
    logic                  num1_need;
    logic [REG_ADDR_W-1:0] num1_addr;
    logic                  num2_need;
    logic [REG_ADDR_W-1:0] num2_addr;
    logic                  write_reg_need;
    logic [REG_ADDR_W-1:0] write_reg_addr;
  } ISSUE_QUEUE_ELEMENT;

endpackage

// File: rtl/issue_scheduler_reg_scoreboard.sv
// Busy-register scoreboard: one set port, NUM_WB clear ports, set beats clear, r0 never busy.
// Lookups are combinational from the registered vector, so a clear is visible one cycle later.
module reg_scoreboard
  import issue_scheduler_pkg::*;
#(
  parameter int NUM_WB = WB_PORTS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_valid,
  input  logic [REG_ADDR_W-1:0]        set_addr,
  input  logic [NUM_WB-1:0]            clr_valid,
  input  logic [NUM_WB*REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0]        look_addr0,
  input  logic [REG_ADDR_W-1:0]        look_addr1,
  input  logic [REG_ADDR_W-1:0]        look_addr2,
  output logic [2:0]                   is_busy,
  output logic [REG_NUM-1:0]           busy_vec
);

  logic [REG_NUM-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_vec;
    for (int k = 0; k < NUM_WB; k++) begin
      if (clr_valid[k]) busy_nxt[clr_addr[k*REG_ADDR_W +: REG_ADDR_W]] = 1'b0;
    end
    // Applied after the clears so an issuing producer keeps its bit.
    if (set_valid) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end

  assign is_busy = {busy_vec[look_addr2], busy_vec[look_addr1], busy_vec[look_addr0]};

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue FIFO: releases the head only when its sources/destination are not busy.
// Flush empties the queue next cycle but leaves the scoreboard intact for older producers.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int NUM_WB = WB_PORTS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  ISSUE_QUEUE_ELEMENT           enq_elem,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output ISSUE_QUEUE_ELEMENT           iss_elem,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*REG_ADDR_W-1:0] wb_addr,
  output logic [REG_NUM-1:0]           busy_vec,
  output logic [$clog2(DEPTH):0]       count,
  output logic [31:0]                  stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  ISSUE_QUEUE_ELEMENT mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          full, empty, enq_fire, iss_fire;
  logic          raw1, raw2, waw, hazard, set_valid;
  logic [2:0]    is_busy;

  assign full      = (count == PW'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = !full && !flush;
  assign enq_fire  = enq_valid && enq_ready;

  assign iss_elem  = mem[rptr[AW-1:0]];
  assign raw1      = iss_elem.num1_need      && (iss_elem.num1_addr      != '0) && is_busy[0];
  assign raw2      = iss_elem.num2_need      && (iss_elem.num2_addr      != '0) && is_busy[1];
  assign waw       = iss_elem.write_reg_need && (iss_elem.write_reg_addr != '0) && is_busy[2];
  assign hazard    = raw1 || raw2 || waw;
  assign iss_valid = !empty && !flush && !hazard;
  assign iss_fire  = iss_valid && iss_ready;
  assign set_valid = iss_fire && iss_elem.write_reg_need && (iss_elem.write_reg_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (enq_fire) wptr <= wptr + 1'b1;
        if (iss_fire) rptr <= rptr + 1'b1;
        count <= count + {{(PW-1){1'b0}}, enq_fire} - {{(PW-1){1'b0}}, iss_fire};
      end
      if (!empty && !flush && hazard && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Storage carries no reset; the head is only meaningful while iss_valid is high.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wptr[AW-1:0]] <= enq_elem;
  end

  reg_scoreboard #(.NUM_WB(NUM_WB)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_valid  (set_valid),
    .set_addr   (iss_elem.write_reg_addr),
    .clr_valid  (wb_valid),
    .clr_addr   (wb_addr),
    .look_addr0 (iss_elem.num1_addr),
    .look_addr1 (iss_elem.num2_addr),
    .look_addr2 (iss_elem.write_reg_addr),
    .is_busy    (is_busy),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench: hazard vector table, issue-order scoreboard, and hand sequences.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               enq_valid = 1'b0;
  logic               enq_ready;
  ISSUE_QUEUE_ELEMENT enq_elem = '0;
  logic               iss_valid;
  logic               iss_ready = 1'b0;
  ISSUE_QUEUE_ELEMENT iss_elem;
  logic [1:0]         wb_valid = '0;
  logic [9:0]         wb_addr = '0;
  logic [31:0]        busy_vec;
  logic [3:0]         count;
  logic [31:0]        stall_cnt;

  int checks = 0;
  int errors = 0;
  ISSUE_QUEUE_ELEMENT exp_q[$];
  ISSUE_QUEUE_ELEMENT nop_e = '0;

  typedef struct {
    logic       n1n; logic [4:0] n1;
    logic       n2n; logic [4:0] n2;
    logic       wn;  logic [4:0] w;
    logic [4:0] busy_reg;
    logic       exp_valid;
  } vec_t;
  vec_t vecs[8];

  issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_elem(enq_elem),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_elem(iss_elem),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy_vec(busy_vec), .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic ISSUE_QUEUE_ELEMENT mk(input logic [31:0] pc,
      input logic n1n, input logic [4:0] n1, input logic n2n, input logic [4:0] n2,
      input logic wn, input logic [4:0] w);
    ISSUE_QUEUE_ELEMENT e;
    e.pc = pc; e.op = pc[7:2];
    e.num1_need = n1n; e.num1_addr = n1;
    e.num2_need = n2n; e.num2_addr = n2;
    e.write_reg_need = wn; e.write_reg_addr = w;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; record what the DUT accepted.
  task automatic step(input logic ev, input ISSUE_QUEUE_ELEMENT e, input logic ir,
                      input logic fl, input logic [1:0] wv, input logic [9:0] wa);
    @(negedge clk);
    enq_valid = ev; enq_elem = e; iss_ready = ir; flush = fl; wb_valid = wv; wb_addr = wa;
    #1;
    if (ev && enq_ready) exp_q.push_back(e);
    if (fl) exp_q.delete();
  endtask

  task automatic idle(input logic ir);
    step(1'b0, nop_e, ir, 1'b0, 2'b00, 10'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enq_valid = 1'b0; iss_ready = 1'b0; flush = 1'b0; wb_valid = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue-order scoreboard: every fire must match the oldest accepted element.
  always @(negedge clk) begin
    #2;
    if (!rst && iss_valid && iss_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL iss_order: fire of pc %h but no element expected", iss_elem.pc);
      end else begin
        ISSUE_QUEUE_ELEMENT x;
        x = exp_q.pop_front();
        if (iss_elem !== x) begin
          errors++;
          $display("FAIL iss_order: got %h expected %h", iss_elem, x);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 5'd6, 1'b0};
    vecs[1] = '{1'b0, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 5'd6, 1'b1};
    vecs[2] = '{1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 5'd0, 5'd6, 1'b0};
    vecs[3] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 5'd6, 1'b0};
    vecs[4] = '{1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd9, 5'd6, 1'b1};
    vecs[5] = '{1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 5'd0, 1'b1};
    vecs[6] = '{1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 5'd6, 5'd6, 1'b0};
    vecs[7] = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6, 5'd6, 1'b1};

    // Reset state
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    do_reset();

    // Single producer: offered one cycle after enqueue, then marks r2 busy
    step(1'b1, mk(32'h100, 1, 5'd1, 0, 5'd0, 1, 5'd2), 1'b1, 1'b0, 2'b00, 10'd0);
    chk("t1_valid_empty", 32'(iss_valid), 32'd0);
    idle(1'b1);
    chk("t1_valid", 32'(iss_valid), 32'd1);
    idle(1'b1);
    chk("t1_busy", busy_vec, 32'h0000_0004);
    chk("t1_count", 32'(count), 32'd0);

    // RAW stall released one cycle after writeback
    do_reset();
    step(1'b1, mk(32'h200, 1, 5'd1, 0, 5'd0, 1, 5'd2), 1'b1, 1'b0, 2'b00, 10'd0);
    step(1'b1, mk(32'h204, 1, 5'd2, 1, 5'd4, 1, 5'd3), 1'b1, 1'b0, 2'b00, 10'd0);
    idle(1'b1);
    chk("t2_stall_valid", 32'(iss_valid), 32'd0);
    chk("t2_stall0", stall_cnt, 32'd0);
    idle(1'b1);
    chk("t2_stall1", stall_cnt, 32'd1);
    step(1'b0, nop_e, 1'b1, 1'b0, 2'b01, {5'd0, 5'd2});
    chk("t2_no_bypass", 32'(iss_valid), 32'd0);
    chk("t2_stall2", stall_cnt, 32'd2);
    idle(1'b1);
    chk("t2_release", 32'(iss_valid), 32'd1);
    chk("t2_stall3", stall_cnt, 32'd3);
    idle(1'b1);
    chk("t2_busy", busy_vec, 32'h0000_0008);
    chk("t2_stall_hold", stall_cnt, 32'd3);

    // Fill to full, reject the extra element, drain in order; twice to wrap pointers
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 9; i++) begin
        step(1'b1, mk(32'h300 + 32'(b*64 + i*4), 0, 5'd0, 0, 5'd0, 0, 5'd0),
             (i == 8) && (b == 1), 1'b0, 2'b00, 10'd0);
        if (i == 7) chk("t3_ready_7", 32'(enq_ready), 32'd1);
      end
      chk("t3_full_count", 32'(count), 32'd8);
      chk("t3_full_ready", 32'(enq_ready), 32'd0);
      for (int i = 0; i < 9; i++) idle(1'b1);
      chk("t3_drained", 32'(count), 32'd0);
      chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
    end

    // Flush keeps the scoreboard; late writeback still clears it
    do_reset();
    step(1'b1, mk(32'h500, 0, 5'd0, 0, 5'd0, 1, 5'd5), 1'b1, 1'b0, 2'b00, 10'd0);
    idle(1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(32'h504 + 32'(i*4), 0, 5'd0, 0, 5'd0, 0, 5'd0), 1'b0, 1'b0, 2'b00, 10'd0);
    idle(1'b0);
    chk("t4_count3", 32'(count), 32'd3);
    step(1'b1, mk(32'h5F0, 0, 5'd0, 0, 5'd0, 0, 5'd0), 1'b1, 1'b1, 2'b00, 10'd0);
    chk("t4_flush_valid", 32'(iss_valid), 32'd0);
    chk("t4_flush_ready", 32'(enq_ready), 32'd0);
    idle(1'b1);
    chk("t4_count0", 32'(count), 32'd0);
    chk("t4_valid0", 32'(iss_valid), 32'd0);
    chk("t4_busy5", busy_vec, 32'h0000_0020);
    step(1'b0, nop_e, 1'b1, 1'b0, 2'b10, {5'd5, 5'd0});
    idle(1'b1);
    chk("t4_cleared", busy_vec, 32'd0);

    // Set wins over a stray writeback; r0 is never marked busy
    do_reset();
    step(1'b1, mk(32'h600, 0, 5'd0, 0, 5'd0, 1, 5'd7), 1'b1, 1'b0, 2'b00, 10'd0);
    step(1'b0, nop_e, 1'b1, 1'b0, 2'b01, {5'd0, 5'd7});
    idle(1'b1);
    chk("t5_set_wins", busy_vec, 32'h0000_0080);
    step(1'b1, mk(32'h604, 0, 5'd0, 0, 5'd0, 1, 5'd0), 1'b1, 1'b0, 2'b00, 10'd0);
    idle(1'b1);
    idle(1'b1);
    chk("t5_r0", busy_vec, 32'h0000_0080);

    // Hazard decode table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      if (vecs[v].busy_reg != 5'd0) begin
        step(1'b1, mk(32'h700, 0, 5'd0, 0, 5'd0, 1, vecs[v].busy_reg), 1'b1, 1'b0, 2'b00, 10'd0);
        idle(1'b1);
      end
      step(1'b1, mk(32'h800 + 32'(v*4), vecs[v].n1n, vecs[v].n1, vecs[v].n2n, vecs[v].n2,
                    vecs[v].wn, vecs[v].w), 1'b0, 1'b0, 2'b00, 10'd0);
      idle(1'b0);
      chk($sformatf("vec%0d_valid", v), 32'(iss_valid), 32'(vecs[v].exp_valid));
      idle(1'b0);
      chk($sformatf("vec%0d_stall", v), stall_cnt, vecs[v].exp_valid ? 32'd0 : 32'd1);
    end

    // Asynchronous reset mid-burst clears state before the next edge
    do_reset();
    step(1'b1, mk(32'h900, 0, 5'd0, 0, 5'd0, 1, 5'd9), 1'b1, 1'b0, 2'b00, 10'd0);
    idle(1'b1);
    step(1'b1, mk(32'h904, 1, 5'd9, 0, 5'd0, 0, 5'd0), 1'b0, 1'b0, 2'b00, 10'd0);
    for (int i = 1; i < 5; i++)
      step(1'b1, mk(32'h904 + 32'(i*4), 0, 5'd0, 0, 5'd0, 0, 5'd0), 1'b0, 1'b0, 2'b00, 10'd0);
    idle(1'b0);
    chk("t6_pre_count", 32'(count), 32'd5);
    chk("t6_pre_busy", busy_vec, 32'h0000_0200);
    chk("t6_pre_stall", 32'(stall_cnt != 0), 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_busy", busy_vec, 32'd0);
    chk("t6_stall", stall_cnt, 32'd0);
    chk("t6_valid", 32'(iss_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
